// File: rtl/fetch_stall_receiver_if.sv
// Stall-control, fetch and pipeline-register signals between the hazard unit,
// instruction memory and the fetch/IF-ID/ID-EX register block.
interface fetch_stall_receiver_if #(
  parameter int CTRL_W = 9
);
  logic              pc_write;
  logic              if_id_write;
  logic              control_sel;
  logic              branch_taken;
  logic [31:0]       branch_target;
  logic [31:0]       instr_in;
  logic [CTRL_W-1:0] ctrl_in;
  logic [31:0]       pc_out;
  logic [31:0]       if_id_pc;
  logic [31:0]       if_id_instr;
  logic              if_id_valid;
  logic [CTRL_W-1:0] id_ex_ctrl;
  logic              id_ex_valid;
  logic [15:0]       stall_count;
  logic              protocol_err;

  modport master (
    output pc_write, if_id_write, control_sel, branch_taken, branch_target,
           instr_in, ctrl_in,
    input  pc_out, if_id_pc, if_id_instr, if_id_valid, id_ex_ctrl,
           id_ex_valid, stall_count, protocol_err
  );

  modport slave (
    input  pc_write, if_id_write, control_sel, branch_taken, branch_target,
           instr_in, ctrl_in,
    output pc_out, if_id_pc, if_id_instr, if_id_valid, id_ex_ctrl,
           id_ex_valid, stall_count, protocol_err
  );
endinterface

// File: rtl/fetch_stall_receiver.sv
// PC, IF/ID and ID/EX control registers driven by hazard stall controls, with
// branch redirect/flush, a saturating stall counter and a sticky incoherence flag.
module fetch_stall_receiver #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CTRL_W    = 9
) (
  input  logic clk,
  input  logic rst,
  fetch_stall_receiver_if.slave bus
);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [31:0]       pc_q, pc_d;
  logic [31:0]       if_id_pc_q, if_id_pc_d;
  logic [31:0]       if_id_instr_q, if_id_instr_d;
  logic              if_id_valid_q, if_id_valid_d;
  logic [CTRL_W-1:0] id_ex_ctrl_q, id_ex_ctrl_d;
  logic              id_ex_valid_q, id_ex_valid_d;
  logic [15:0]       stall_count_q, stall_count_d;
  logic              protocol_err_q, protocol_err_d;
  logic              incoherent;

  // Each control steers its own register independently; a branch overrides all.
  always_comb begin
    pc_d           = pc_q;
    if_id_pc_d     = if_id_pc_q;
    if_id_instr_d  = if_id_instr_q;
    if_id_valid_d  = if_id_valid_q;
    id_ex_ctrl_d   = '0;
    id_ex_valid_d  = 1'b0;
    stall_count_d  = stall_count_q;
    incoherent     = !bus.branch_taken &&
                     !((bus.pc_write == bus.if_id_write) &&
                       (bus.if_id_write == bus.control_sel));
    protocol_err_d = protocol_err_q | incoherent;

    if (bus.branch_taken) begin
      pc_d          = bus.branch_target & 32'hFFFF_FFFC;
      if_id_pc_d    = 32'h0;
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
    end else begin
      if (bus.pc_write) begin
        pc_d = pc_q + 32'd4;
      end else begin
        stall_count_d = sat_inc16(stall_count_q);
      end
      if (bus.if_id_write) begin
        if_id_pc_d    = pc_q;
        if_id_instr_d = bus.instr_in;
        if_id_valid_d = 1'b1;
      end
      if (bus.control_sel) begin
        id_ex_ctrl_d  = bus.ctrl_in;
        id_ex_valid_d = if_id_valid_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      if_id_pc_q     <= 32'h0;
      if_id_instr_q  <= NOP_INSTR;
      if_id_valid_q  <= 1'b0;
      id_ex_ctrl_q   <= '0;
      id_ex_valid_q  <= 1'b0;
      stall_count_q  <= 16'h0;
      protocol_err_q <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      if_id_pc_q     <= if_id_pc_d;
      if_id_instr_q  <= if_id_instr_d;
      if_id_valid_q  <= if_id_valid_d;
      id_ex_ctrl_q   <= id_ex_ctrl_d;
      id_ex_valid_q  <= id_ex_valid_d;
      stall_count_q  <= stall_count_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign bus.pc_out       = pc_q;
  assign bus.if_id_pc     = if_id_pc_q;
  assign bus.if_id_instr  = if_id_instr_q;
  assign bus.if_id_valid  = if_id_valid_q;
  assign bus.id_ex_ctrl   = id_ex_ctrl_q;
  assign bus.id_ex_valid  = id_ex_valid_q;
  assign bus.stall_count  = stall_count_q;
  assign bus.protocol_err = protocol_err_q;

endmodule

// File: tb/tb_fetch_stall_receiver.sv
// Scoreboard bench for fetch_stall_receiver: directed scenarios plus random
// stall/branch/reset traffic against a cycle-level reference model.
module tb_fetch_stall_receiver;
  localparam int          CTRL_W    = 9;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_stall_receiver_if #(.CTRL_W(CTRL_W)) bus ();

  fetch_stall_receiver #(
    .RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR), .CTRL_W(CTRL_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       ipc;
    logic [31:0]       iins;
    logic              iv;
    logic [CTRL_W-1:0] ctrl;
    logic              ev;
    logic [15:0]       sc;
    logic              pe;
  } exp_t;

  exp_t q[$];
  int   tests  = 0;
  int   failed = 0;

  // Reference state: what each output should read after the next edge.
  exp_t m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Monitor: every registered output is sampled 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("pc_out",       bus.pc_out,                 e.pc);
        chk("if_id_pc",     bus.if_id_pc,               e.ipc);
        chk("if_id_instr",  bus.if_id_instr,            e.iins);
        chk("if_id_valid",  {31'h0, bus.if_id_valid},   {31'h0, e.iv});
        chk("id_ex_ctrl",   {23'h0, bus.id_ex_ctrl},    {23'h0, e.ctrl});
        chk("id_ex_valid",  {31'h0, bus.id_ex_valid},   {31'h0, e.ev});
        chk("stall_count",  {16'h0, bus.stall_count},   {16'h0, e.sc});
        chk("protocol_err", {31'h0, bus.protocol_err},  {31'h0, e.pe});
      end
    end
  end

  // Drive one cycle of inputs and record what the outputs must be after it.
  task automatic step(input logic r, input logic pw, input logic iw, input logic cs,
                      input logic bt, input logic [31:0] bta,
                      input logic [31:0] ins, input logic [CTRL_W-1:0] ctl);
    exp_t n;
    @(negedge clk);
    rst               = r;
    bus.pc_write      = pw;
    bus.if_id_write   = iw;
    bus.control_sel   = cs;
    bus.branch_taken  = bt;
    bus.branch_target = bta;
    bus.instr_in      = ins;
    bus.ctrl_in       = ctl;
    if (r) begin
      n = '{pc: RESET_PC, ipc: 32'h0, iins: NOP_INSTR, iv: 1'b0,
            ctrl: '0, ev: 1'b0, sc: 16'h0, pe: 1'b0};
    end else if (bt) begin
      n      = m;
      n.pc   = {bta[31:2], 2'b00};
      n.ipc  = 32'h0;
      n.iins = NOP_INSTR;
      n.iv   = 1'b0;
      n.ctrl = '0;
      n.ev   = 1'b0;
    end else begin
      n      = m;
      n.pc   = pw ? m.pc + 32'd4 : m.pc;
      if (iw) begin
        n.ipc  = m.pc;
        n.iins = ins;
        n.iv   = 1'b1;
      end
      n.ctrl = cs ? ctl : '0;
      n.ev   = cs ? m.iv : 1'b0;
      if (!pw && m.sc != 16'hFFFF) n.sc = m.sc + 16'd1;
      if (!(pw == iw && iw == cs)) n.pe = 1'b1;
    end
    m = n;
    q.push_back(n);
  endtask

  task automatic run(input logic pw, input logic iw, input logic cs, input logic [31:0] ins,
                     input logic [CTRL_W-1:0] ctl);
    step(1'b0, pw, iw, cs, 1'b0, 32'h0, ins, ctl);
  endtask

  task automatic branch(input logic [31:0] tgt);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, tgt, 32'h0, '0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, '0);
  endtask

  initial begin
    logic        pw, iw, cs, bt, r;
    logic [31:0] ins, tgt;
    m = '0;
    bus.pc_write = 1'b0; bus.if_id_write = 1'b0; bus.control_sel = 1'b0;
    bus.branch_taken = 1'b0; bus.branch_target = 32'h0;
    bus.instr_in = 32'h0; bus.ctrl_in = '0;

    // Straight-line fetch, then a 2-cycle stall at pc 0x10.
    do_reset();
    for (int i = 0; i < 4; i++) run(1'b1, 1'b1, 1'b1, 32'h00A0_0093, 9'h055);
    for (int i = 0; i < 2; i++) run(1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 9'h1FF);
    run(1'b1, 1'b1, 1'b1, 32'h0011_2233, 9'h0AA);

    // Branch with all stall controls low: redirect, flush, no count.
    branch(32'h0000_0103);
    run(1'b1, 1'b1, 1'b1, 32'h0040_0113, 9'h101);

    // Incoherent cycle then coherent traffic: flag is sticky.
    run(1'b1, 1'b0, 1'b1, 32'h1234_5678, 9'h0F0);
    for (int i = 0; i < 3; i++) run(1'b1, 1'b1, 1'b1, 32'h8765_4321, 9'h00F);

    // PC wrap at the top of the address space.
    branch(32'hFFFF_FFFE);
    run(1'b1, 1'b1, 1'b1, 32'hCAFE_0001, 9'h1);
    run(1'b1, 1'b1, 1'b1, 32'hCAFE_0002, 9'h2);

    // Reset in the middle of a stall with stall_count=5.
    do_reset();
    for (int i = 0; i < 3; i++) run(1'b1, 1'b1, 1'b1, 32'h0000_0100 + i, 9'h3);
    for (int i = 0; i < 5; i++) run(1'b0, 1'b0, 1'b0, 32'h0, 9'h1FF);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0400, 32'h0, 9'h1FF);
    run(1'b1, 1'b1, 1'b1, 32'h00A0_0093, 9'h7);

    // Random traffic, mostly coherent controls.
    for (int i = 0; i < 2000; i++) begin
      r   = ($urandom_range(0, 99) < 2);
      bt  = ($urandom_range(0, 99) < 10);
      pw  = $urandom_range(0, 1);
      iw  = pw;
      cs  = pw;
      if ($urandom_range(0, 99) < 15) begin
        iw = $urandom_range(0, 1);
        cs = $urandom_range(0, 1);
      end
      ins = $urandom;
      tgt = $urandom;
      step(r, pw, iw, cs, bt, tgt, ins, CTRL_W'($urandom));
    end

    // Long stall run drives stall_count into saturation.
    do_reset();
    for (int i = 0; i < 65540; i++) run(1'b0, 1'b0, 1'b0, $urandom, CTRL_W'($urandom));
    run(1'b1, 1'b1, 1'b1, 32'h00A0_0093, 9'h11);

    repeat (3) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain: actual=%0d expected=0 pending entries", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/fetch_stall_receiver.md
FETCH_STALL_RECEIVER -- requirements
Module: fetch_stall_receiver

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), instruction word used for IF/ID flush and reset.
REQ-003 Parameter CTRL_W, default 9, width of the decoded control bundle passed ID->EX.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 pc_write  input  1  from hazard stall logic; 1 = advance PC, 0 = hold PC.
REQ-007 if_id_write  input  1  from hazard stall logic; 1 = load IF/ID, 0 = hold IF/ID.
REQ-008 control_sel  input  1  from hazard stall logic; 1 = pass ctrl_in to ID/EX, 0 = insert bubble.
REQ-009 branch_taken  input  1  resolved taken branch/jump this cycle.
REQ-010 branch_target  input  32  redirect address, valid when branch_taken=1.
REQ-011 instr_in  input  32  instruction memory read data for current pc_out (combinational read).
REQ-012 ctrl_in  input  CTRL_W  decoded control bits of instruction in IF/ID.
REQ-013 pc_out  output  32  current fetch PC.
REQ-014 if_id_pc / if_id_instr / if_id_valid  output  32/32/1  IF/ID pipeline register contents.
REQ-015 id_ex_ctrl / id_ex_valid  output  CTRL_W/1  ID/EX control register contents.
REQ-016 stall_count  output  16  number of stalled cycles since reset.
REQ-017 protocol_err  output  1  sticky flag: incoherent stall control observed.

Function
REQ-018 Priority per cycle SHALL be: rst > branch_taken > stall (pc_write=0) > normal advance.
REQ-019 Normal advance (pc_write=1, no branch): pc_out SHALL become pc_out+4, modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
REQ-020 Stall (pc_write=0, no branch): pc_out SHALL hold its value.
REQ-021 Branch: pc_out SHALL become {branch_target[31:2],2'b00}, regardless of pc_write.
REQ-022 if_id_write=1, no branch: IF/ID SHALL capture pc_out, instr_in, valid=1 on the next edge (1-cycle latency).
REQ-023 if_id_write=0, no branch: IF/ID SHALL hold all three fields unchanged.
REQ-024 Branch: IF/ID SHALL load if_id_instr=NOP_INSTR, if_id_valid=0, if_id_pc=0, overriding if_id_write.
REQ-025 control_sel=1, no branch: id_ex_ctrl SHALL load ctrl_in; id_ex_valid SHALL load if_id_valid.
REQ-026 control_sel=0 or branch: id_ex_ctrl SHALL load all-zero; id_ex_valid SHALL load 0 (bubble).
REQ-027 stall_count SHALL increment by 1 on each edge where pc_write=0 and branch_taken=0, saturating at 16'hFFFF.
REQ-028 A cycle SHALL count as incoherent when pc_write, if_id_write and control_sel are not all equal and branch_taken=0.
REQ-029 protocol_err SHALL set on the edge after an incoherent cycle and remain 1 until rst; datapath SHALL still follow REQ-019..026 per signal independently.
REQ-030 Consecutive stall cycles of any length SHALL keep PC and IF/ID frozen and insert one bubble per stalled cycle.
REQ-031 Branch coinciding with stall SHALL redirect and flush; the stall cycle SHALL not be counted.

Reset
REQ-032 On rst=1 at a rising edge: pc_out=RESET_PC, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0, id_ex_ctrl=0, id_ex_valid=0, stall_count=0, protocol_err=0.
REQ-033 rst asserted mid-stall or mid-branch SHALL override all inputs; first post-reset fetch SHALL be from RESET_PC.
REQ-034 No output SHALL change except on a clk rising edge.

Verification
REQ-035 Reset then 3 cycles all-ones stall controls, instr_in=0x00A00093 -> pc_out 0,4,8,12; if_id_pc 0,4,8; if_id_valid=1 from cycle 2.
REQ-036 Hold pc_write=if_id_write=control_sel=0 for 2 cycles at pc_out=0x10, ctrl_in=9'h1FF -> pc_out stays 0x10, IF/ID unchanged, id_ex_ctrl=0 for 2 cycles, stall_count=2.
REQ-037 branch_taken=1, branch_target=0x0000_0103, controls all 0 -> pc_out=0x100, if_id_instr=0x00000013, if_id_valid=0, id_ex_valid=0, stall_count unchanged.
REQ-038 Drive pc_write=1, if_id_write=0, control_sel=1 one cycle -> protocol_err=1 next cycle and stays 1 with coherent inputs until rst.
REQ-039 Force pc_out=0xFFFF_FFFC via branch, then advance -> pc_out=0x0000_0000; 65536 stall cycles -> stall_count=0xFFFF, holds.
REQ-040 Assert rst during a stall with stall_count=5 -> all outputs at REQ-032 values next edge, pc_out=RESET_PC.
